fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/skid_buf2.sv | 71 +++++++
 rtl/fifo_burst_reader.sv | 99 +++++++++
 tb/tb_fifo_burst_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg -- shared FIFO-slice types, default widths and SyncFIFO geometry.
// Rev 1.0
// ============================================================================
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 16;

  localparam int SYNC_FIFO_DEPTH = 16;
  localparam int SYNC_FIFO_AW    = $clog2(SYNC_FIFO_DEPTH);

  localparam int BUF_CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// skid_buf2 -- two-entry FIFO-ordered output buffer; dout is the oldest entry.
// Rev 1.0
// ============================================================================
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic [BUF_CNT_W-1:0] cnt
);

  logic [WIDTH-1:0]     head_q, head_d;
  logic [WIDTH-1:0]     tail_q, tail_d;
  logic [BUF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 do_pop;
  logic                 do_push;

  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din;
        else               tail_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = head_q;
  assign cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// fifo_burst_reader -- pops bursts of cmd_len words from a FWFT FIFO into a stream.
// Rev 1.0
// ============================================================================
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             empty,
  input  logic             fifo_wen,
  output logic             rEn,
  input  logic [WIDTH-1:0] dOut,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_total
);

  rd_state_e            state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [CNT_W-1:0]     words_total_q, words_total_d;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [WIDTH-1:0]     buf_dout;
  logic                 pop_en;
  logic                 xfer;

  // Pop decision uses only registered state and FIFO flags, never m_ready.
  assign pop_en = (state_q == ST_BURST) && (remaining_q != '0) &&
                  (!empty || fifo_wen) && (buf_cnt < 2'd2);
  assign xfer   = (buf_cnt != '0) && m_ready;

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (pop_en),
    .din  (dOut),
    .pop  (xfer),
    .dout (buf_dout),
    .cnt  (buf_cnt)
  );

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    words_total_d = words_total_q + CNT_W'(xfer);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_len;
          state_d     = (cmd_len != '0) ? ST_BURST : ST_DRAIN;
        end
      end
      ST_BURST: begin
        if (remaining_q == '0)  state_d     = ST_DRAIN;
        else if (pop_en)        remaining_d = remaining_q - LEN_W'(1);
      end
      ST_DRAIN: begin
        if (buf_cnt == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      words_total_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      words_total_q <= words_total_d;
    end
  end

  assign rEn         = pop_en;
  assign m_valid     = (buf_cnt != '0);
  assign m_data      = buf_dout;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  // DRAIN never pops, so an empty buffer here marks the completing cycle.
  assign done        = (state_q == ST_DRAIN) && (buf_cnt == '0);
  assign words_total = words_total_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_fifo_burst_reader -- vector table plus corner sequences, FIFO model and scoreboard.
// Rev 1.0
// ============================================================================
module tb_fifo_burst_reader;

  localparam int WIDTH = 5;
  localparam int LEN_W = 4;
  localparam int CNT_W = 16;
  localparam int NV    = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             empty = 1'b1;
  logic             fifo_wen = 1'b0;
  logic             rEn;
  logic [WIDTH-1:0] dOut = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_total;

  fifo_burst_reader #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .empty       (empty),
    .fifo_wen    (fifo_wen),
    .rEn         (rEn),
    .dOut        (dOut),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .done        (done),
    .words_total (words_total)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] data_next = '0;
  logic [WIDTH-1:0] wen_data  = '0;
  int  rdy_mode = 0;
  bit  fill_en  = 1'b0;
  bit  wen_req  = 1'b0;
  longint exp_words = 0;

  int cyc = 0, n_pops = 0, n_xfer = 0, n_done = 0, n_valid = 0;
  int accept_cyc = -1, done_cyc = -1, first_xfer_cyc = -1, last_xfer_cyc = -1;
  bit prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  typedef struct {
    int len;
    int preload;
    int rdy;
    bit fill;
    bit consec;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // FIFO model and ready driver: FWFT head on dOut, optional bypass write.
  always @(negedge clk) begin
    #1;
    if (fill_en && fq.size() < 6 && $urandom_range(0, 1) == 1) begin
      fq.push_back(data_next);
      data_next++;
    end
    empty    = (fq.size() == 0);
    fifo_wen = wen_req && (fq.size() == 0);
    dOut     = (fq.size() != 0) ? fq[0] : (fifo_wen ? wen_data : '0);
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: samples just before the rising edge, pops the model, scores output.
  always @(negedge clk) begin
    #3;
    cyc++;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid) n_valid++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL xfer_unexpected: got data %0d expected no transfer", m_data);
        end else begin
          check("xfer_data", m_data, exp_q.pop_front());
        end
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        n_xfer++;
      end
      if (rEn) begin
        n_pops++;
        if (fq.size() != 0) begin
          exp_q.push_back(fq.pop_front());
        end else if (fifo_wen) begin
          exp_q.push_back(wen_data);
          wen_req = 1'b0;
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_empty: got rEn=1 expected 0 (FIFO empty, no write)");
        end
      end else if (fifo_wen) begin
        fq.push_back(wen_data);
        wen_req = 1'b0;
      end
      if (cmd_valid && cmd_ready) accept_cyc = cyc;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic send_cmd(input int len);
    int k = 0;
    @(negedge clk); #2;
    while (!cmd_ready && k < 200) begin
      @(negedge clk); #2;
      k++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    first_xfer_cyc = -1;
    accept_cyc     = -1;
    done_cyc       = -1;
    cmd_len        = LEN_W'(len);
    cmd_valid      = 1'b1;
    @(negedge clk); #2;
    cmd_valid      = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input int budget);
    int k = 0;
    while (n_done == base_done && k < budget) begin
      @(negedge clk); #4;
      k++;
    end
    if (n_done == base_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse expected one within %0d cycles", budget);
    end
    repeat (2) begin
      @(negedge clk); #4;
    end
  endtask

  task automatic preload(input int n);
    for (int j = 0; j < n; j++) begin
      fq.push_back(data_next);
      data_next++;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bd, bp, bx, bv, total, ncmd, len;
    logic [WIDTH-1:0] s0;

    vecs[0] = '{len: 4,  preload: 4,  rdy: 0, fill: 1'b0, consec: 1'b1};
    vecs[1] = '{len: 0,  preload: 0,  rdy: 0, fill: 1'b0, consec: 1'b0};
    vecs[2] = '{len: 1,  preload: 1,  rdy: 0, fill: 1'b0, consec: 1'b1};
    vecs[3] = '{len: 15, preload: 15, rdy: 0, fill: 1'b0, consec: 1'b1};
    vecs[4] = '{len: 9,  preload: 3,  rdy: 1, fill: 1'b1, consec: 1'b0};
    vecs[5] = '{len: 2,  preload: 0,  rdy: 1, fill: 1'b1, consec: 1'b0};

    // Asynchronous reset: outputs must settle without any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rEn", rEn, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_data", m_data, 0);
    check("rst_words_total", words_total, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      fill_en  = vecs[i].fill;
      rdy_mode = vecs[i].rdy;
      preload(vecs[i].preload);
      bd = n_done; bp = n_pops; bv = n_valid;
      send_cmd(vecs[i].len);
      wait_done(bd, 300);
      fill_en = 1'b0;
      exp_words += vecs[i].len;
      check($sformatf("v%0d_done_count", i), n_done - bd, 1);
      check($sformatf("v%0d_pops", i), n_pops - bp, vecs[i].len);
      check($sformatf("v%0d_scoreboard_empty", i), exp_q.size(), 0);
      check($sformatf("v%0d_words_total", i), words_total, exp_words);
      if (vecs[i].len == 0) begin
        check($sformatf("v%0d_done_latency", i), done_cyc - accept_cyc, 1);
        check($sformatf("v%0d_no_valid", i), n_valid - bv, 0);
      end else begin
        check($sformatf("v%0d_done_after_last", i), done_cyc - last_xfer_cyc, 1);
      end
      if (vecs[i].consec)
        check($sformatf("v%0d_back_to_back", i), last_xfer_cyc - first_xfer_cyc, vecs[i].len - 1);
    end

    // Stall for 10 cycles: two pops fill the buffer, then resume without loss.
    fq.delete();
    rdy_mode = 2;
    s0 = data_next;
    preload(5);
    bd = n_done; bp = n_pops; bx = n_xfer;
    send_cmd(5);
    repeat (10) begin
      @(negedge clk); #4;
    end
    check("stall_pops", n_pops - bp, 2);
    check("stall_valid", m_valid, 1);
    check("stall_head", m_data, s0);
    rdy_mode = 0;
    wait_done(bd, 100);
    exp_words += 5;
    check("stall_done_count", n_done - bd, 1);
    check("stall_xfers", n_xfer - bx, 5);
    check("stall_words_total", words_total, exp_words);

    // Bypass: empty FIFO with a write in flight still allows a pop.
    fq.delete();
    rdy_mode = 0;
    bd = n_done;
    send_cmd(1);
    check("bypass_wait_rEn", rEn, 0);
    wen_data = 5'd7;
    wen_req  = 1'b1;
    @(negedge clk); #2;
    check("bypass_rEn", rEn, 1);
    @(negedge clk); #2;
    check("bypass_valid", m_valid, 1);
    check("bypass_data", m_data, 7);
    wait_done(bd, 50);
    exp_words += 1;
    check("bypass_words_total", words_total, exp_words);

    // Reset mid-burst with 3 words still to pop.
    fq.delete();
    rdy_mode = 0;
    preload(6);
    send_cmd(5);
    repeat (2) begin
      @(negedge clk); #2;
    end
    check("midrst_pre_rEn", rEn, 1);
    check("midrst_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_rEn", rEn, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_m_data", m_data, 0);
    exp_q.delete();
    fq.delete();
    exp_words = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_words_total", words_total, 0);

    // Random fill and stalls: 500 words in bursts of 0..15.
    fill_en  = 1'b1;
    rdy_mode = 1;
    total = 0;
    ncmd  = 0;
    bd = n_done; bx = n_xfer;
    while (total < 500) begin
      len = $urandom_range(0, 15);
      if (len > 500 - total) len = 500 - total;
      send_cmd(len);
      wait_done(bd + ncmd, 400);
      total += len;
      ncmd++;
    end
    fill_en = 1'b0;
    check("rand_done_count", n_done - bd, ncmd);
    check("rand_xfers", n_xfer - bx, 500);
    check("rand_words_total", words_total, 500);
    check("rand_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
